// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
package sar_pkg;

    localparam int unsigned ADC_BITS = 10;
    localparam int unsigned OSR_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2
    } seq_state_t;

    function automatic logic [OSR_W-1:0] osr_clamp(input logic [OSR_W-1:0] osr,
                                                   input logic [OSR_W-1:0] osr_max);
        return (osr > osr_max) ? osr_max : osr;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// Single-clock FIFO with registered read port; occupancy counter separates full from empty.
module sar_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign level   = count_q;
    // A pop frees the slot the same-cycle push writes into, so full+pop accepts both.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                rd_data  <= mem[rd_ptr_q];
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Drives sarlogic starts, averages 2^osr results into a host FIFO, and recovers from lost valids.
module sar_conv_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned OSR_MAX = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   run,
    input  logic                   cal_req,
    input  logic [OSR_W-1:0]       osr,
    input  logic                   adc_valid,
    input  logic [ADC_BITS-1:0]    adc_result,
    output logic                   adc_en,
    output logic                   adc_cal,
    input  logic                   rd_en,
    output logic [ADC_BITS-1:0]    rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   tmo,
    input  logic                   clr_flags
);

    localparam int unsigned ACC_W = ADC_BITS + OSR_MAX;
    localparam int unsigned CNT_W = OSR_MAX;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam logic [OSR_W-1:0] OSR_MAX_L = OSR_W'(OSR_MAX);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);

    seq_state_t          state_q, state_d;
    logic                cal_pend_q;
    logic                kind_q;
    logic [WD_W-1:0]     wdog_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OSR_W-1:0]    osr_l_q;
    logic                ovf_q;
    logic                tmo_q;

    logic [OSR_W-1:0]    osr_eff;
    logic [CNT_W-1:0]    cnt_last;
    logic [ACC_W-1:0]    acc_sum;
    logic [ADC_BITS-1:0] push_data;
    logic                sample;
    logic                push;
    logic                drop;
    logic                timeout_hit;

    // Ratio is taken live at the first sample of an average and frozen until it completes.
    assign osr_eff     = (cnt_q == '0) ? osr_clamp(osr, OSR_MAX_L) : osr_l_q;
    assign cnt_last    = CNT_W'((1 << osr_eff) - 1);
    assign acc_sum     = acc_q + ACC_W'(adc_result);
    assign push_data   = ADC_BITS'(acc_sum >> osr_eff);
    assign sample      = (state_q == S_BUSY) && adc_valid && !kind_q;
    assign push        = sample && (cnt_q == cnt_last);
    assign drop        = push && full && !rd_en;
    assign timeout_hit = (state_q == S_BUSY) && !adc_valid && (wdog_q == WD_LAST);

    assign ovf = ovf_q;
    assign tmo = tmo_q;

    always_comb begin
        state_d = state_q;
        adc_en  = 1'b0;
        adc_cal = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run || cal_pend_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                adc_en  = 1'b1;
                adc_cal = cal_pend_q;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (adc_valid || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cal_pend_q <= 1'b0;
            kind_q     <= 1'b0;
            wdog_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            osr_l_q    <= '0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            // A request landing in the start cycle stays pending for the following start.
            cal_pend_q <= ((state_q == S_START) ? 1'b0 : cal_pend_q) | cal_req;
            if (state_q == S_START) begin
                kind_q <= cal_pend_q;
            end
            wdog_q  <= (state_q == S_BUSY) ? wdog_q + 1'b1 : '0;
            osr_l_q <= osr_eff;
            if (timeout_hit || push) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (sample) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + 1'b1;
            end
            ovf_q <= drop | (ovf_q & ~clr_flags);
            tmo_q <= timeout_hit | (tmo_q & ~clr_flags);
        end
    end

    sar_sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ADC_BITS)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_data(push_data),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level)
    );

endmodule
